// File: rtl/clock_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_step_ctrl
// Description : CPU clock-enable generator with run / single-step / halt
//               modes. Produces a one-clk cpu_ce pulse either from a free
//               running divider (RUN) or from a debounced step button (STEP).
//               HALT stops all pulses until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_step_ctrl #(
    parameter int DIV      = 262144,  // board clocks per cpu_ce in RUN
    parameter int DEBOUNCE = 65536    // stable clocks to accept a button level
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_sw,
    input  logic       step_btn,
    input  logic       halt,
    output logic       cpu_ce,
    output logic [1:0] state_out,
    output logic [7:0] ce_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int c_DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(DIV - 1);
    localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_STEP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic               r_run_meta_q, r_run_sync_q;
    logic               r_btn_meta_q, r_btn_sync_q;
    logic               r_btn_acc_q,  w_btn_acc_d;
    logic [c_DB_W-1:0]  r_db_cnt_q,   w_db_cnt_d;
    logic               r_press_q,    w_press_d;
    state_e             r_state_q,    w_state_d;
    logic [c_DIV_W-1:0] r_div_cnt_q,  w_div_cnt_d;
    logic               r_cpu_ce_q,   w_cpu_ce_d;
    logic [7:0]         r_ce_count_q, w_ce_count_d;

    // Two-flop synchronizers for the raw asynchronous switch and button
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_meta_q <= 1'b0;
            r_run_sync_q <= 1'b0;
            r_btn_meta_q <= 1'b0;
            r_btn_sync_q <= 1'b0;
        end else begin
            r_run_meta_q <= run_sw;
            r_run_sync_q <= r_run_meta_q;
            r_btn_meta_q <= step_btn;
            r_btn_sync_q <= r_btn_meta_q;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE consecutive clocks of
    // disagreement; any agreement restarts the count. A rising accepted level
    // is a press, but it is kept only while in STEP so that presses made in
    // RUN or HALT (or straddling a mode change) are simply dropped.
    always_comb begin
        w_btn_acc_d = r_btn_acc_q;
        w_db_cnt_d  = '0;
        w_press_d   = 1'b0;
        if (r_btn_sync_q != r_btn_acc_q) begin
            if (r_db_cnt_q == c_DB_MAX) begin
                w_btn_acc_d = r_btn_sync_q;
                w_press_d   = r_btn_sync_q && (r_state_q == ST_STEP);
            end else begin
                w_db_cnt_d = r_db_cnt_q + 1'b1;
            end
        end
    end

    // Mode FSM next state: halt has priority, HALT is only left through rst,
    // and the unused code 11 falls back to STEP.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_STEP: begin
                if (halt) begin
                    w_state_d = ST_HALT;
                end else if (r_run_sync_q) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    w_state_d = ST_HALT;
                end else if (!r_run_sync_q) begin
                    w_state_d = ST_STEP;
                end
            end
            ST_HALT: begin
                w_state_d = ST_HALT;
            end
            default: begin
                w_state_d = ST_STEP;
            end
        endcase
    end

    // Divider: counts only while staying in RUN, so it reads 0 in every other
    // state and restarts from 0 on each entry to RUN.
    always_comb begin
        w_div_cnt_d = '0;
        if ((r_state_q == ST_RUN) && (w_state_d == ST_RUN)) begin
            if (r_div_cnt_q == c_DIV_MAX) begin
                w_div_cnt_d = '0;
            end else begin
                w_div_cnt_d = r_div_cnt_q + 1'b1;
            end
        end
    end

    // Clock-enable source selection; halt vetoes any pulse for the next clk
    always_comb begin
        w_cpu_ce_d = 1'b0;
        if (!halt) begin
            case (r_state_q)
                ST_RUN:  w_cpu_ce_d = (r_div_cnt_q == c_DIV_MAX);
                ST_STEP: w_cpu_ce_d = r_press_q;
                default: w_cpu_ce_d = 1'b0;
            endcase
        end
    end

    // Pulse counter, advancing once for every clk in which cpu_ce is high
    always_comb begin
        w_ce_count_d = r_ce_count_q;
        if (r_cpu_ce_q) begin
            w_ce_count_d = r_ce_count_q + 8'd1;
        end
    end

    // State registers for debouncer, FSM, divider and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_acc_q  <= 1'b0;
            r_db_cnt_q   <= '0;
            r_press_q    <= 1'b0;
            r_state_q    <= ST_STEP;
            r_div_cnt_q  <= '0;
            r_cpu_ce_q   <= 1'b0;
            r_ce_count_q <= 8'd0;
        end else begin
            r_btn_acc_q  <= w_btn_acc_d;
            r_db_cnt_q   <= w_db_cnt_d;
            r_press_q    <= w_press_d;
            r_state_q    <= w_state_d;
            r_div_cnt_q  <= w_div_cnt_d;
            r_cpu_ce_q   <= w_cpu_ce_d;
            r_ce_count_q <= w_ce_count_d;
        end
    end

    assign cpu_ce    = r_cpu_ce_q;
    assign state_out = r_state_q;
    assign ce_count  = r_ce_count_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_step_ctrl
// Description : Self-checking bench for clock_step_ctrl (DIV = 4,
//               DEBOUNCE = 3): a vector table for reset/RUN timing plus
//               directed sequences for step, halt, debounce and wrap cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_step_ctrl;

    localparam int c_DIV      = 4;
    localparam int c_DEBOUNCE = 3;
    localparam int c_NVEC     = 28;

    typedef struct {
        logic rst;
        logic run_sw;
        logic step_btn;
        logic halt;
        int   exp_ce;
        int   exp_state;
        int   exp_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_sw;
    logic       step_btn;
    logic       halt;
    logic       cpu_ce;
    logic [1:0] state_out;
    logic [7:0] ce_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   pulses  = 0;
    int   b2b     = 0;
    logic prev_ce = 1'b0;
    vec_t vecs [c_NVEC];

    clock_step_ctrl #(
        .DIV      (c_DIV),
        .DEBOUNCE (c_DEBOUNCE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .halt      (halt),
        .cpu_ce    (cpu_ce),
        .state_out (state_out),
        .ce_count  (ce_count)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts cpu_ce pulses and flags back-to-back pulses
    always begin
        @(posedge clk);
        #2;
        if (cpu_ce === 1'b1) begin
            pulses = pulses + 1;
            if (prev_ce) b2b = b2b + 1;
        end
        prev_ce = (cpu_ce === 1'b1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two reset clocks, then release; the next posedge is edge 1 after reset
    task automatic do_reset(input logic run, input logic btn);
        @(negedge clk);
        rst      = 1'b1;
        run_sw   = run;
        step_btn = btn;
        halt     = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        int lat;
        int cyc;

        // Vector table: reset, RUN start-up and five divider periods, then a
        // mid-period reset. Row r drives before edge r and checks after it.
        for (int r = 0; r < c_NVEC; r++) begin
            vecs[r].rst       = (r < 2) || (r == 26);
            vecs[r].run_sw    = (r < 27);
            vecs[r].step_btn  = 1'b0;
            vecs[r].halt      = 1'b0;
            vecs[r].exp_state = (r >= 4 && r <= 25) ? 1 : 0;
            vecs[r].exp_ce    = (r >= 8 && r <= 25 && ((r - 8) % 4 == 0)) ? 1 : 0;
            vecs[r].exp_cnt   = (r >= 9 && r <= 25) ? ((r - 9) / 4 + 1) : 0;
        end

        for (int r = 0; r < c_NVEC; r++) begin
            rst      = vecs[r].rst;
            run_sw   = vecs[r].run_sw;
            step_btn = vecs[r].step_btn;
            halt     = vecs[r].halt;
            @(negedge clk);
            chk($sformatf("vec%0d_ce", r),    int'(cpu_ce),    vecs[r].exp_ce);
            chk($sformatf("vec%0d_state", r), int'(state_out), vecs[r].exp_state);
            chk($sformatf("vec%0d_cnt", r),   int'(ce_count),  vecs[r].exp_cnt);
        end

        // Bouncing button in STEP, then a solid hold: exactly one pulse
        do_reset(1'b0, 1'b0);
        tick(3);
        chk("step_idle_state", int'(state_out), 0);
        chk("step_cnt_before", int'(ce_count), 0);
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            step_btn = (i % 2 == 0);
            tick(1);
        end
        step_btn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (cpu_ce === 1'b1 && lat == 0) lat = k;
        end
        chk("step_press_latency", lat, 6);
        step_btn = 1'b0;
        tick(8);
        chk("step_bounce_pulses", pulses - p0, 1);
        chk("step_bounce_cnt", int'(ce_count), 1);

        // Debounce boundary: 2 clocks high is rejected, 3 clocks is accepted
        step_btn = 1'b1;
        tick(2);
        step_btn = 1'b0;
        tick(8);
        chk("glitch2_pulses", pulses - p0, 1);
        step_btn = 1'b1;
        tick(3);
        step_btn = 1'b0;
        tick(8);
        chk("hold3_pulses", pulses - p0, 2);
        chk("hold3_cnt", int'(ce_count), 2);

        // Halt in the same cycle the divider is at its last count
        do_reset(1'b1, 1'b0);
        p0 = pulses;
        tick(10);
        chk("halt_pre_state", int'(state_out), 1);
        halt = 1'b1;
        tick(1);
        chk("halt_ce_suppressed", int'(cpu_ce), 0);
        chk("halt_state", int'(state_out), 2);
        chk("halt_cnt", int'(ce_count), 1);
        halt = 1'b0;
        for (int i = 0; i < 24; i++) begin
            run_sw   = (i % 2 == 0);
            step_btn = ((i / 6) % 2 == 1);
            tick(1);
        end
        step_btn = 1'b0;
        tick(4);
        chk("halt_no_pulses", pulses - p0, 1);
        chk("halt_stays", int'(state_out), 2);
        rst = 1'b1;
        tick(1);
        chk("rst_halt_state", int'(state_out), 0);
        chk("rst_halt_ce", int'(cpu_ce), 0);
        chk("rst_halt_cnt", int'(ce_count), 0);
        rst = 1'b0;

        // RUN -> STEP, three clean presses, then back to RUN
        do_reset(1'b1, 1'b0);
        tick(12);
        run_sw = 1'b0;
        tick(6);
        chk("r2s_state", int'(state_out), 0);
        p0 = pulses;
        repeat (3) begin
            step_btn = 1'b1;
            tick(6);
            step_btn = 1'b0;
            tick(6);
        end
        chk("three_presses", pulses - p0, 3);
        run_sw = 1'b1;
        cyc = 0;
        while (state_out != 2'b01 && cyc < 10) begin
            tick(1);
            cyc++;
        end
        chk("s2r_state", int'(state_out), 1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (cpu_ce === 1'b1 && lat == 0) lat = k;
        end
        chk("s2r_first_pulse", lat, 4);

        // 300 steady RUN pulses wrap the 8-bit counter to 44
        do_reset(1'b1, 1'b0);
        p0  = pulses;
        cyc = 0;
        while ((pulses - p0) < 300 && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        chk("run300_pulses", pulses - p0, 300);
        tick(1);
        chk("run300_cnt_wrap", int'(ce_count), 44);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("rst_run_state", int'(state_out), 0);
        chk("rst_run_ce", int'(cpu_ce), 0);
        chk("rst_run_cnt", int'(ce_count), 0);
        rst = 1'b0;

        // Button already held through reset yields one press after debounce
        do_reset(1'b0, 1'b1);
        p0 = pulses;
        tick(12);
        chk("held_btn_pulses", pulses - p0, 1);
        chk("held_btn_cnt", int'(ce_count), 1);
        step_btn = 1'b0;
        tick(8);

        chk("no_back_to_back", b2b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
